// File: rtl/mac_table_reader_pkg.sv
// Shared types and constants for the per-port GMII receive path and the switch MAC table.
package gmii_router_definitions;

  localparam int unsigned PORT_NUMBER    = 4;
  localparam int unsigned PORT_W         = $clog2(PORT_NUMBER);
  localparam int unsigned MAC_TABLE_SIZE = 16;
  localparam int unsigned TBL_W          = $clog2(MAC_TABLE_SIZE);
  localparam logic [7:0]  GMII_SFD       = 8'hD5;

  typedef struct packed {
    logic [7:0] data;
    logic       dv;
    logic       err;
  } gmii_interface;

  typedef struct packed {
    logic              valid;
    logic [47:0]       mac;
    logic [PORT_W-1:0] port;
  } mac_table_entry;

  typedef mac_table_entry [MAC_TABLE_SIZE-1:0] switch_table;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DST_MAC,
    SEARCH,
    DONE,
    WAIT_END
  } reader_state_t;

  function automatic logic [PORT_NUMBER-1:0] port_onehot(input logic [PORT_W-1:0] p);
    port_onehot = PORT_NUMBER'(1) << p;
  endfunction

  function automatic logic [PORT_NUMBER-1:0] flood_mask(input int unsigned this_port);
    flood_mask = ~(PORT_NUMBER'(1) << this_port);
  endfunction

endpackage

// File: rtl/mac_table_reader_if.sv
// Ingress GMII stream and route-decision outputs of one receive port.
interface mac_table_reader_if;
  import gmii_router_definitions::*;

  gmii_interface          gmii_rxd_in;
  logic                   route_valid;
  logic [PORT_NUMBER-1:0] route_mask;
  logic                   route_hit;
  logic                   busy;

  modport master (
    output gmii_rxd_in,
    input  route_valid, route_mask, route_hit, busy
  );

  modport slave (
    input  gmii_rxd_in,
    output route_valid, route_mask, route_hit, busy
  );
endinterface

// File: rtl/mac_table_reader_dst_capture.sv
// Shifts in the six destination-MAC bytes following the SFD and tracks header errors.
module gmii_dst_mac_capture
  import gmii_router_definitions::*;
(
  input  logic          clk,
  input  logic          rst,
  input  reader_state_t state,
  input  gmii_interface gmii,
  output logic [47:0]   dst_mac,
  output logic          dst_valid,
  output logic          dst_drop
);

  logic [47:0] dst_q;
  logic [2:0]  cnt_q;
  logic        drop_q;
  logic [47:0] shifted;
  logic        hdr_byte;

  // The complete address is presented combinationally in the byte-5 cycle so the
  // reader can decide group/drop without waiting for the register to settle.
  always_comb begin
    shifted   = {dst_q[39:0], gmii.data};
    hdr_byte  = (state == DST_MAC) && gmii.dv;
    dst_valid = hdr_byte && (cnt_q == 3'd5);
    dst_mac   = dst_valid ? shifted : dst_q;
    dst_drop  = drop_q || (hdr_byte && gmii.err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else if (state == PREAMBLE) begin
      if (gmii.dv && (gmii.data == GMII_SFD)) begin
        cnt_q  <= '0;
        drop_q <= 1'b0;
      end
    end else if (hdr_byte) begin
      dst_q  <= shifted;
      cnt_q  <= cnt_q + 3'd1;
      drop_q <= dst_drop;
    end
  end

endmodule

// File: rtl/mac_table_reader.sv
// Per-frame route decision: captures the destination MAC and scans the switch table one entry per clock.
module mac_table_reader
  import gmii_router_definitions::*;
#(
  parameter int unsigned THIS_PORT  = 0,
  parameter int unsigned TABLE_SIZE = MAC_TABLE_SIZE
)(
  input  logic        clk,
  input  logic        rst,
  input  switch_table src_MAC_table,
  mac_table_reader_if.slave bus
);

  localparam logic [PORT_NUMBER-1:0] FLOOD    = flood_mask(THIS_PORT);
  localparam logic [TBL_W-1:0]       LAST_IDX = TBL_W'(TABLE_SIZE - 1);
  localparam logic [PORT_W-1:0]      OWN_PORT = PORT_W'(THIS_PORT);

  reader_state_t          state_q, state_d;
  logic [TBL_W-1:0]       idx_q, idx_d;
  logic [PORT_NUMBER-1:0] mask_q, mask_d;
  logic                   hit_q, hit_d;
  logic                   gap_q;

  gmii_interface  rx;
  logic [47:0]    dst_mac;
  logic           dst_valid;
  logic           dst_drop;
  mac_table_entry entry;
  logic           entry_match;

  assign rx = bus.gmii_rxd_in;

  gmii_dst_mac_capture u_capture (
    .clk       (clk),
    .rst       (rst),
    .state     (state_q),
    .gmii      (rx),
    .dst_mac   (dst_mac),
    .dst_valid (dst_valid),
    .dst_drop  (dst_drop)
  );

  // gap_q records that dv was low last cycle; it starts cleared so a frame cut by
  // reset is ignored until the line goes quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      hit_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      hit_q   <= hit_d;
      gap_q   <= !rx.dv;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    hit_d       = hit_q;
    entry       = src_MAC_table[idx_q];
    entry_match = entry.valid && (entry.mac == dst_mac);

    unique case (state_q)
      IDLE: begin
        if (rx.dv && gap_q) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (!rx.dv)                      state_d = IDLE;
        else if (rx.data == GMII_SFD)    state_d = DST_MAC;
      end
      DST_MAC: begin
        if (!rx.dv) begin
          state_d = IDLE;
        end else if (dst_valid) begin
          if (dst_drop) begin
            state_d = DONE;
            mask_d  = '0;
            hit_d   = 1'b0;
          end else if (dst_mac[40]) begin
            state_d = DONE;
            mask_d  = FLOOD;
            hit_d   = 1'b0;
          end else begin
            state_d = SEARCH;
            idx_d   = '0;
          end
        end
      end
      SEARCH: begin
        if (entry_match) begin
          state_d = DONE;
          hit_d   = 1'b1;
          mask_d  = (entry.port == OWN_PORT) ? '0 : port_onehot(entry.port);
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
          mask_d  = FLOOD;
          hit_d   = 1'b0;
        end else begin
          idx_d = idx_q + TBL_W'(1);
        end
      end
      DONE: begin
        state_d = rx.dv ? WAIT_END : IDLE;
      end
      WAIT_END: begin
        if (!rx.dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.route_valid = (state_q == DONE);
    bus.route_mask  = mask_q;
    bus.route_hit   = hit_q;
    bus.busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mac_table_reader.sv
// Two readers (ingress ports 0 and 1) share one GMII stream and table; results are compared with a frame-level model.
module tb_mac_table_reader;
  import gmii_router_definitions::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gmii_interface rx;
  switch_table   tbl;

  mac_table_reader_if if0 ();
  mac_table_reader_if if1 ();
  assign if0.gmii_rxd_in = rx;
  assign if1.gmii_rxd_in = rx;

  mac_table_reader #(.THIS_PORT(0), .TABLE_SIZE(16)) dut0 (
    .clk(clk), .rst(rst), .src_MAC_table(tbl), .bus(if0)
  );
  mac_table_reader #(.THIS_PORT(1), .TABLE_SIZE(16)) dut1 (
    .clk(clk), .rst(rst), .src_MAC_table(tbl), .bus(if1)
  );

  typedef struct { int cyc; logic [3:0] mask; logic hit; } pulse_t;
  pulse_t q0[$];
  pulse_t q1[$];

  always @(negedge clk) begin
    if (if0.route_valid) q0.push_back('{cyc, if0.route_mask, if0.route_hit});
    if (if1.route_valid) q1.push_back('{cyc, if1.route_mask, if1.route_hit});
  end

  typedef struct {
    string       name;
    logic [47:0] dst;
    int          err_byte;
    int          mac_bytes;
    int          payload;
    int          exp_n;
    int          lat;
    logic [3:0]  m0;
    logic        h0;
    logic [3:0]  m1;
    logic        h1;
  } vec_t;
  vec_t vecs[14];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic dv, input logic er);
    rx.data = d;
    rx.dv   = dv;
    rx.err  = er;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string name, input logic [47:0] dst, input int err_byte,
                            input int mac_bytes, input int payload, input int pre_len,
                            input int err_pay, output int l_cyc);
    l_cyc = -1;
    chk({name, ".busy_before"}, {if1.busy, if0.busy}, 2'b00);
    put(8'h55, 1'b1, 1'b0);
    chk({name, ".busy_rise"}, {if1.busy, if0.busy}, 2'b11);
    for (int i = 1; i < pre_len; i++) put(8'h55, 1'b1, 1'b0);
    put(GMII_SFD, 1'b1, 1'b0);
    for (int i = 0; i < mac_bytes; i++) begin
      if (i == 5) l_cyc = cyc;
      put(dst[47-8*i -: 8], 1'b1, err_byte == i);
    end
    if (mac_bytes < 6) begin
      put(8'h00, 1'b0, 1'b0);
      chk({name, ".busy_abort"}, {if1.busy, if0.busy}, 2'b00);
    end else begin
      for (int i = 0; i < payload; i++) put(8'($urandom), 1'b1, err_pay == i);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    put(8'h00, 1'b0, 1'b0);
    while ((if0.busy || if1.busy) && n < 60) begin
      put(8'h00, 1'b0, 1'b0);
      n++;
    end
    chk({name, ".idle_bound"}, 64'(n < 60), 64'd1);
  endtask

  task automatic check_route(input string name, input int exp_n, input int exp_cyc,
                             input logic [3:0] m0, input logic h0,
                             input logic [3:0] m1, input logic h1);
    chk({name, ".pulses0"}, q0.size(), exp_n);
    chk({name, ".pulses1"}, q1.size(), exp_n);
    if (exp_n == 1 && q0.size() == 1) begin
      chk({name, ".cycle0"}, q0[0].cyc, exp_cyc);
      chk({name, ".mask0"}, q0[0].mask, m0);
      chk({name, ".hit0"}, q0[0].hit, h0);
    end
    if (exp_n == 1 && q1.size() == 1) begin
      chk({name, ".cycle1"}, q1[0].cyc, exp_cyc);
      chk({name, ".mask1"}, q1[0].mask, m1);
      chk({name, ".hit1"}, q1[0].hit, h1);
    end
    q0.delete();
    q1.delete();
  endtask

  // Frame-level reference: group/drop decide immediately, otherwise first valid match in index order.
  function automatic void predict(input logic [47:0] dst, input bit hdr_err, input int unsigned tp,
                                  output int lat, output logic [3:0] mask, output logic hit);
    logic [3:0] flood;
    flood = 4'hF & ~(4'b0001 << tp);
    lat = 17; mask = flood; hit = 1'b0;
    if (hdr_err) begin
      lat = 1; mask = 4'b0000;
    end else if (dst[40]) begin
      lat = 1;
    end else begin
      for (int k = 15; k >= 0; k--)
        if (tbl[k].valid && tbl[k].mac == dst) begin
          lat  = 2 + k;
          hit  = 1'b1;
          mask = (int'(tbl[k].port) == tp) ? 4'b0000 : (4'b0001 << tbl[k].port);
        end
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int l1, l2, lat0, lat1, n_exp;
    logic [3:0] m0, m1;
    logic h0, h1;
    logic [47:0] d;
    int eb, mb, pl, ep, k;

    tbl = '0;
    tbl[0]  = '{valid: 1'b1, mac: 48'h00AA00000001, port: 2'd3};
    tbl[3]  = '{valid: 1'b1, mac: 48'h001122334455, port: 2'd2};
    tbl[5]  = '{valid: 1'b1, mac: 48'h00AA00000005, port: 2'd0};
    tbl[7]  = '{valid: 1'b1, mac: 48'h00AA00000007, port: 2'd1};
    tbl[9]  = '{valid: 1'b0, mac: 48'h020000000009, port: 2'd2};
    tbl[10] = '{valid: 1'b1, mac: 48'h00AA0000000C, port: 2'd3};
    tbl[12] = '{valid: 1'b1, mac: 48'h00AA0000000C, port: 2'd2};
    tbl[15] = '{valid: 1'b1, mac: 48'h00AA0000000F, port: 2'd2};

    vecs[0]  = '{"hit_e3",     48'h001122334455, -1, 6, 20, 1,  5, 4'b0100, 1'b1, 4'b0100, 1'b1};
    vecs[1]  = '{"bcast",      48'hFFFFFFFFFFFF, -1, 6, 20, 1,  1, 4'b1110, 1'b0, 4'b1101, 1'b0};
    vecs[2]  = '{"miss",       48'h020000000001, -1, 6, 20, 1, 17, 4'b1110, 1'b0, 4'b1101, 1'b0};
    vecs[3]  = '{"filter_p0",  48'h00AA00000005, -1, 6, 20, 1,  7, 4'b0000, 1'b1, 4'b0001, 1'b1};
    vecs[4]  = '{"filter_p1",  48'h00AA00000007, -1, 6, 20, 1,  9, 4'b0010, 1'b1, 4'b0000, 1'b1};
    vecs[5]  = '{"err_b2",     48'h001122334455,  2, 6, 20, 1,  1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{"invalid_e9", 48'h020000000009, -1, 6, 20, 1, 17, 4'b1110, 1'b0, 4'b1101, 1'b0};
    vecs[7]  = '{"dup_first",  48'h00AA0000000C, -1, 6, 20, 1, 12, 4'b1000, 1'b1, 4'b1000, 1'b1};
    vecs[8]  = '{"last_e15",   48'h00AA0000000F, -1, 6,  0, 1, 17, 4'b0100, 1'b1, 4'b0100, 1'b1};
    vecs[9]  = '{"mcast",      48'h01005E000001, -1, 6, 20, 1,  1, 4'b1110, 1'b0, 4'b1101, 1'b0};
    vecs[10] = '{"trunc3",     48'h001122334455, -1, 3,  0, 0,  0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[11] = '{"err_b5",     48'h00AA00000001,  5, 6, 20, 1,  1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[12] = '{"hit_e0",     48'h00AA00000001, -1, 6,  0, 1,  2, 4'b1000, 1'b1, 4'b1000, 1'b1};
    vecs[13] = '{"trunc0",     48'h00AA00000001, -1, 0,  0, 0,  0, 4'b0000, 1'b0, 4'b0000, 1'b0};

    rst = 1'b1;
    rx  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outs0", {if0.route_valid, if0.route_mask, if0.route_hit, if0.busy}, 7'd0);
    chk("reset.outs1", {if1.route_valid, if1.route_mask, if1.route_hit, if1.busy}, 7'd0);
    rst = 1'b0;
    put(8'h00, 1'b0, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    q0.delete();
    q1.delete();

    for (int v = 0; v < 14; v++) begin
      send_frame(vecs[v].name, vecs[v].dst, vecs[v].err_byte, vecs[v].mac_bytes,
                 vecs[v].payload, 7, -1, l1);
      wait_idle(vecs[v].name);
      check_route(vecs[v].name, vecs[v].exp_n, l1 + vecs[v].lat,
                  vecs[v].m0, vecs[v].h0, vecs[v].m1, vecs[v].h1);
    end

    // Reset in the middle of a search; the tail of the frame carries a fake SFD and a known MAC.
    send_frame("rst_search", 48'h020000000001, -1, 6, 4, 7, -1, l1);
    rst = 1'b1;
    put(8'h11, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_search.busy", {if1.busy, if0.busy}, 2'b00);
    put(8'h55, 1'b1, 1'b0);
    put(8'h55, 1'b1, 1'b0);
    put(GMII_SFD, 1'b1, 1'b0);
    d = 48'h00AA00000001;
    for (int i = 0; i < 6; i++) put(d[47-8*i -: 8], 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) put(8'h00, 1'b1, 1'b0);
    wait_idle("rst_search");
    check_route("rst_search", 0, 0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    send_frame("after_rst", 48'h001122334455, -1, 6, 20, 7, -1, l1);
    wait_idle("after_rst");
    check_route("after_rst", 1, l1 + 5, 4'b0100, 1'b1, 4'b0100, 1'b1);

    // Back-to-back frames separated by a single idle cycle.
    send_frame("b2b_1", 48'h00AA00000001, -1, 6, 10, 7, -1, l1);
    put(8'h00, 1'b0, 1'b0);
    send_frame("b2b_2", 48'h00AA00000001, -1, 6, 10, 7, -1, l2);
    wait_idle("b2b");
    chk("b2b.pulses0", q0.size(), 2);
    chk("b2b.pulses1", q1.size(), 2);
    if (q0.size() == 2 && q1.size() == 2) begin
      chk("b2b.cycle_a", q0[0].cyc, l1 + 2);
      chk("b2b.cycle_b", q1[1].cyc, l2 + 2);
      chk("b2b.route_a", {q0[0].mask, q0[0].hit, q1[0].mask, q1[0].hit}, {4'b1000, 1'b1, 4'b1000, 1'b1});
      chk("b2b.route_b", {q0[1].mask, q0[1].hit, q1[1].mask, q1[1].hit}, {4'b1000, 1'b1, 4'b1000, 1'b1});
    end
    q0.delete();
    q1.delete();

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(1) == 1) begin
        k = $urandom_range(15);
        tbl[k].valid = 1'($urandom_range(1));
        tbl[k].mac   = {16'h00AA, 24'h000000, 8'($urandom_range(15))};
        tbl[k].port  = 2'($urandom_range(3));
      end
      case ($urandom_range(9))
        0, 1, 2, 3, 4: d = tbl[$urandom_range(15)].mac;
        5:             d = 48'hFFFFFFFFFFFF;
        6:             d = {24'h01005E, 24'($urandom)};
        default: begin
          d = {16'($urandom), 32'($urandom)};
          d[40] = 1'b0;
        end
      endcase
      eb = ($urandom_range(7) == 0) ? int'($urandom_range(5)) : -1;
      mb = ($urandom_range(7) == 0) ? int'($urandom_range(5)) : 6;
      pl = $urandom_range(30);
      ep = (pl > 0 && $urandom_range(3) == 0) ? int'($urandom_range(pl - 1)) : -1;
      predict(d, eb >= 0, 0, lat0, m0, h0);
      predict(d, eb >= 0, 1, lat1, m1, h1);
      n_exp = (mb == 6) ? 1 : 0;
      send_frame($sformatf("rand%0d", f), d, eb, mb, pl, $urandom_range(1, 7), ep, l1);
      wait_idle($sformatf("rand%0d", f));
      check_route($sformatf("rand%0d", f), n_exp, l1 + lat0, m0, h0, m1, h1);
      chk($sformatf("rand%0d.lat_agree", f), lat0, lat1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
